// File: rtl/sram_1r1w_init.sv
// sram_1r1w_init: parametrised single-clock 1R1W SRAM model with lane write
// mask, write-first same-address bypass, read-valid handshake and a
// zero-initialisation sequencer that owns the array after reset.
//
// Optional build macro SRAM_OUT_REG_EN: adds a second output register stage
// (read latency 2, rd_valid pipelined with the data). Undefined: latency 1.
//
// state  | meaning
// -------+-------------------------------------------------------------
// INIT   | sequencer writes 0 to mem[cnt] each cycle; user ports ignored
// READY  | normal read/write service until the next reset
module sram_1r1w_init #(
  parameter int WIDTH     = 72,
  parameter int DEPTH     = 128,
  parameter int MASK_GRAN = 8,
  localparam int ADDR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int NLANES   = WIDTH / MASK_GRAN
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data,
  output logic              rd_valid,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [NLANES-1:0] wr_mask,
  output logic              init_busy
);

  // One extra bit so DEPTH itself is representable for range compares.
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST_C  = DEPTH_C - 1'b1;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                init_busy_q, init_busy_d;

  logic [WIDTH-1:0]    mem_q [DEPTH];

  logic                rd_in_range, wr_in_range;
  logic                rd_acc, wr_acc, bypass;
  logic [WIDTH-1:0]    rd_word;

  logic [WIDTH-1:0]    rd_data_q, rd_data_d;
  logic                rd_valid_q, rd_valid_d;

  // Sequencer next state: walk cnt from 0 to DEPTH-1, then park in READY.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_INIT) begin
      if ({1'b0, cnt_q} == LAST_C) begin
        state_d = ST_READY;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    init_busy_d = (state_d == ST_INIT);
  end

  // Sequencer state, counter and registered busy flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      init_busy_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_busy_q <= init_busy_d;
    end
  end

  assign init_busy = init_busy_q;

  // Port acceptance and write-first bypass for a same-address read.
  always_comb begin
    rd_in_range = ({1'b0, rd_addr} < DEPTH_C);
    wr_in_range = ({1'b0, wr_addr} < DEPTH_C);
    rd_acc      = (state_q == ST_READY) && rd_en;
    wr_acc      = (state_q == ST_READY) && wr_en && wr_in_range && !reset;
    bypass      = wr_acc && (wr_addr == rd_addr);
    rd_word     = '0;
    if (rd_in_range) begin
      rd_word = mem_q[rd_addr];
      for (int i = 0; i < NLANES; i++) begin
        if (bypass && wr_mask[i]) begin
          rd_word[i*MASK_GRAN +: MASK_GRAN] = wr_data[i*MASK_GRAN +: MASK_GRAN];
        end
      end
    end
    rd_data_d  = rd_acc ? rd_word : rd_data_q;
    rd_valid_d = rd_acc;
  end

  // Array update: zero-fill while INIT, masked lane writes once READY.
  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) begin
      mem_q[cnt_q] <= '0;
    end else if (wr_acc) begin
      for (int i = 0; i < NLANES; i++) begin
        if (wr_mask[i]) begin
          mem_q[wr_addr][i*MASK_GRAN +: MASK_GRAN] <= wr_data[i*MASK_GRAN +: MASK_GRAN];
        end
      end
    end
  end

  // First read stage; data holds when no read is accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

`ifdef SRAM_OUT_REG_EN
  logic [WIDTH-1:0] rd_data2_q, rd_data2_d;
  logic             rd_valid2_q, rd_valid2_d;

  // Second stage copies stage 1 only when it carries a fresh read.
  always_comb begin
    rd_data2_d  = rd_valid_q ? rd_data_q : rd_data2_q;
    rd_valid2_d = rd_valid_q;
  end

  // Output register stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data2_q  <= '0;
      rd_valid2_q <= 1'b0;
    end else begin
      rd_data2_q  <= rd_data2_d;
      rd_valid2_q <= rd_valid2_d;
    end
  end

  assign rd_data  = rd_data2_q;
  assign rd_valid = rd_valid2_q;
`else
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
`endif

endmodule

// File: tb/tb_sram_1r1w_init.sv
// Directed testbench for sram_1r1w_init at the default geometry
// (72-bit words, 128 entries, 8-bit mask lanes).
module tb_sram_1r1w_init;

  localparam int WIDTH  = 72;
  localparam int DEPTH  = 128;
  localparam int ADDR_W = 7;
  localparam int NLANES = 9;
`ifdef SRAM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [WIDTH-1:0]  rd_data;
  logic              rd_valid;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;
  logic [NLANES-1:0] wr_mask;
  logic              init_busy;

  int tests = 0;
  int fails = 0;

  sram_1r1w_init #(.WIDTH(WIDTH), .DEPTH(DEPTH), .MASK_GRAN(8)) dut (
    .clk(clk), .reset(reset),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask),
    .init_busy(init_busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Counts cycles with init_busy high from the current negedge, bounded.
  task automatic count_busy(output int n);
    n = 0;
    while (init_busy && n < 1000) begin
      tick();
      n++;
    end
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d,
                          input logic [NLANES-1:0] m);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_mask = m;
    tick();
    wr_en = 1'b0; wr_mask = '0;
  endtask

  // Issues one read and returns the output after the read latency.
  task automatic do_read(input logic [ADDR_W-1:0] a, output logic [WIDTH-1:0] d,
                         output logic v);
    rd_en = 1'b1; rd_addr = a;
    tick();
    rd_en = 1'b0;
    for (int k = 1; k < LAT; k++) tick();
    d = rd_data; v = rd_valid;
  endtask

  task automatic test_reset();
    reset = 1'b1; rd_en = 1'b0; wr_en = 1'b0;
    rd_addr = '0; wr_addr = '0; wr_data = '0; wr_mask = '0;
    repeat (3) tick();
    tests++; if (rd_data !== '0) begin fails++; $display("FAIL reset_rd_data got %h want 0", rd_data); end
    tests++; if (rd_valid !== 1'b0) begin fails++; $display("FAIL reset_rd_valid got %b want 0", rd_valid); end
    tests++; if (init_busy !== 1'b1) begin fails++; $display("FAIL reset_init_busy got %b want 1", init_busy); end
  endtask

  // Release reset with rd_en held high and a write to addr 3 in INIT cycle 10.
  task automatic test_init();
    int n;
    int vseen;
    n = 0; vseen = 0;
    reset = 1'b0;
    rd_en = 1'b1; rd_addr = 7'd3;
    while (init_busy && n < 1000) begin
      if (n == 10) begin
        wr_en = 1'b1; wr_addr = 7'd3; wr_data = {9{8'hAA}}; wr_mask = '1;
      end else begin
        wr_en = 1'b0; wr_mask = '0;
      end
      tick();
      n++;
      if (rd_valid) vseen++;
    end
    rd_en = 1'b0; wr_en = 1'b0; wr_mask = '0;
    tick();
    if (rd_valid) vseen++;
    tests++; if (n !== DEPTH) begin fails++; $display("FAIL init_busy_cycles got %0d want %0d", n, DEPTH); end
    tests++; if (vseen !== 0) begin fails++; $display("FAIL init_rd_valid_pulses got %0d want 0", vseen); end
    tests++; if (init_busy !== 1'b0) begin fails++; $display("FAIL init_busy_after got %b want 0", init_busy); end
  endtask

  task automatic test_init_contents();
    logic [WIDTH-1:0] d;
    logic v;
    logic [ADDR_W-1:0] addrs [4];
    addrs = '{7'd0, 7'd64, 7'd127, 7'd3};
    foreach (addrs[i]) begin
      do_read(addrs[i], d, v);
      tests++; if (v !== 1'b1) begin fails++; $display("FAIL init_read_valid addr %0d got %b want 1", addrs[i], v); end
      tests++; if (d !== '0) begin fails++; $display("FAIL init_read_data addr %0d got %h want 0", addrs[i], d); end
    end
    tick();
    tests++; if (rd_valid !== 1'b0) begin fails++; $display("FAIL idle_rd_valid got %b want 0", rd_valid); end
    tests++; if (rd_data !== '0) begin fails++; $display("FAIL idle_rd_data_hold got %h want 0", rd_data); end
  endtask

  task automatic test_masked_write();
    logic [WIDTH-1:0] d;
    logic v;
    do_write(7'd5, 72'hFF_FFFF_FFFF_FFFF_FFFF, 9'h1FF);
    do_write(7'd5, 72'h00_0000_0000_0000_0000, 9'h001);
    do_write(7'd5, 72'h00_0000_0000_0000_0000, 9'h000);
    do_read(7'd5, d, v);
    tests++; if (d !== 72'hFF_FFFF_FFFF_FFFF_FF00) begin fails++; $display("FAIL masked_write got %h want ff_ffff_ffff_ffff_ff00", d); end
    do_write(7'd6, 72'h11_2233_4455_6677_8899, 9'h142);
    do_read(7'd6, d, v);
    tests++; if (d !== 72'h11_0033_0000_0000_8800) begin fails++; $display("FAIL masked_write_lanes got %h want 11_0033_0000_0000_8800", d); end
  endtask

  // Lane i of the 0F0 mask is bits [8i+7:8i]; lanes 4..7 take new data.
  task automatic test_bypass();
    logic [WIDTH-1:0] d;
    logic v;
    wr_en = 1'b1; wr_addr = 7'd9; wr_data = 72'h12_3456_789A_BCDE_F012; wr_mask = 9'h0F0;
    rd_en = 1'b1; rd_addr = 7'd9;
    tick();
    wr_en = 1'b0; wr_mask = '0; rd_en = 1'b0;
    for (int k = 1; k < LAT; k++) tick();
    tests++; if (rd_data !== 72'h00_3456_789A_0000_0000) begin fails++; $display("FAIL bypass_same_addr got %h want 00_3456_789a_0000_0000", rd_data); end
    // Different address in the same cycle: read sees stored data only.
    wr_en = 1'b1; wr_addr = 7'd10; wr_data = '1; wr_mask = '1;
    rd_en = 1'b1; rd_addr = 7'd5;
    tick();
    wr_en = 1'b0; wr_mask = '0; rd_en = 1'b0;
    for (int k = 1; k < LAT; k++) tick();
    tests++; if (rd_data !== 72'hFF_FFFF_FFFF_FFFF_FF00) begin fails++; $display("FAIL bypass_diff_addr got %h want ff_ffff_ffff_ffff_ff00", rd_data); end
    do_read(7'd9, d, v);
    tests++; if (d !== 72'h00_3456_789A_0000_0000) begin fails++; $display("FAIL bypass_stored got %h want 00_3456_789a_0000_0000", d); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) do_write(ADDR_W'(i), WIDTH'(i), '1);
    for (int j = 0; j <= 8 + LAT; j++) begin
      if (j >= LAT && j - LAT < 8) begin
        tests++; if (rd_valid !== 1'b1) begin fails++; $display("FAIL b2b_valid cycle %0d got %b want 1", j, rd_valid); end
        tests++; if (rd_data !== WIDTH'(j - LAT)) begin fails++; $display("FAIL b2b_data cycle %0d got %h want %0d", j, rd_data, j - LAT); end
      end else begin
        tests++; if (rd_valid !== 1'b0) begin fails++; $display("FAIL b2b_idle cycle %0d got %b want 0", j, rd_valid); end
      end
      rd_en = (j < 8); rd_addr = ADDR_W'(j);
      tick();
    end
    rd_en = 1'b0;
  endtask

  task automatic test_reset_mid_op();
    logic [WIDTH-1:0] d;
    logic v;
    int n;
    do_write(7'd0, 72'h1, '1);
    do_read(7'd0, d, v);
    tests++; if (d !== 72'h1) begin fails++; $display("FAIL pre_reset_read got %h want 1", d); end
    rd_en = 1'b1; rd_addr = 7'd0; reset = 1'b1;
    tick();
    rd_en = 1'b0;
    tests++; if (rd_valid !== 1'b0) begin fails++; $display("FAIL reset_drop_valid got %b want 0", rd_valid); end
    tests++; if (init_busy !== 1'b1) begin fails++; $display("FAIL reset_busy got %b want 1", init_busy); end
    tick();
    tests++; if (rd_valid !== 1'b0) begin fails++; $display("FAIL reset_drop_valid2 got %b want 0", rd_valid); end
    reset = 1'b0;
    count_busy(n);
    tests++; if (n !== DEPTH) begin fails++; $display("FAIL reinit_busy_cycles got %0d want %0d", n, DEPTH); end
    do_read(7'd0, d, v);
    tests++; if (v !== 1'b1) begin fails++; $display("FAIL reinit_valid got %b want 1", v); end
    tests++; if (d !== '0) begin fails++; $display("FAIL reinit_addr0 got %h want 0", d); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_init();
    test_init_contents();
    test_masked_write();
    test_bypass();
    test_back_to_back();
    test_reset_mid_op();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
